// File: rtl/quantonium_pkg.sv
// Shared types, constants and helper functions for the QuantoniumOS crypto core.
package quantonium_pkg;

    typedef enum logic [2:0] {
        MODE_RFT  = 3'd0,
        MODE_SIS  = 3'd1,
        MODE_FEI  = 3'd2,
        MODE_PIPE = 3'd3
    } mode_e;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RFT  = 3'd1,
        ST_SIS  = 3'd2,
        ST_FEI  = 3'd3,
        ST_DONE = 3'd4
    } state_e;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    localparam int ROT_RFT = 8;
    localparam int ROT_F   = 13;
    localparam int SHR_F   = 7;

    function automatic logic [15:0] lfsr_step(input logic [15:0] a);
        return a[0] ? ((a >> 1) ^ LFSR_TAPS) : (a >> 1);
    endfunction

    function automatic logic [127:0] rotl128(input logic [127:0] s);
        return (s << ROT_RFT) | (s >> (128 - ROT_RFT));
    endfunction

    function automatic logic [63:0] feistel_f(input logic [63:0] r, input logic [63:0] k);
        logic [63:0] t;
        t = r + k;
        return ((t << ROT_F) | (t >> (64 - ROT_F))) ^ (r >> SHR_F);
    endfunction

    function automatic logic [15:0] popcount256(input logic [255:0] v);
        logic [15:0] n;
        n = 16'd0;
        for (int j = 0; j < 256; j++) begin
            n = n + {15'd0, v[j]};
        end
        return n;
    endfunction

endpackage

// File: rtl/quantonium_feistel_round.sv
// One combinational Feistel round: (L, R) -> (R, L ^ F(R, k)).
module quantonium_feistel_round
    import quantonium_pkg::*;
(
    input  logic [63:0] l_i,
    input  logic [63:0] r_i,
    input  logic [63:0] k_i,
    output logic [63:0] l_o,
    output logic [63:0] r_o
);
    assign l_o = r_i;
    assign r_o = l_i ^ feistel_f(r_i, k_i);
endmodule

// File: rtl/quantonium_unified_core.sv
// QuantoniumOS crypto core: RFT mix, SIS lattice hash, Feistel cipher, or all three chained.
// Define QUANTONIUM_METRICS_EN to build the metric outputs; otherwise they read as constant 0.
module quantonium_unified_core #(
    parameter int RFT_SIZE       = 64,
    parameter int SIS_N          = 512,
    parameter int FEISTEL_ROUNDS = 48
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [2:0]   mode,
    input  logic [255:0] master_key,
    input  logic [127:0] data_in,
    output logic [255:0] data_out,
    output logic         done,
    output logic [31:0]  rft_energy,
    output logic [15:0]  sis_collision_resistance,
    output logic [5:0]   feistel_round_count,
    output logic [31:0]  pipeline_throughput
);
    import quantonium_pkg::*;

    localparam logic [15:0] RFT_LAST = 16'(RFT_SIZE - 1);
    localparam logic [15:0] SIS_LAST = 16'(SIS_N - 1);
    localparam logic [15:0] FEI_LAST = 16'(FEISTEL_ROUNDS - 1);

    state_e         state_q, state_d;
    logic [2:0]     mode_q, mode_d;
    logic [255:0]   key_q, key_d;
    logic [127:0]   x_q, x_d;       // operand of the running stage
    logic [127:0]   w_q, w_d;       // RFT state S, or Feistel {L, R}
    logic [255:0]   h_q, h_d;
    logic [15:0]    a_q, a_d;
    logic [15:0]    i_q, i_d;
    logic [255:0]   data_out_q, data_out_d;
    logic           done_q, done_d;

    logic [7:0]     rft_x_s;
    logic [127:0]   rft_s_s;
    logic [15:0]    a_next_s;
    logic [255:0]   sis_h_s;
    logic [63:0]    round_key_s, fei_l_s, fei_r_s;

    quantonium_feistel_round u_round (
        .l_i (w_q[127:64]),
        .r_i (w_q[63:0]),
        .k_i (round_key_s),
        .l_o (fei_l_s),
        .r_o (fei_r_s)
    );

    // One iteration of each stage computed from the current registers
    always_comb begin
        rft_x_s     = x_q[{i_q[3:0], 3'b000} +: 8];
        rft_s_s     = rotl128(w_q) ^ {120'd0, rft_x_s ^ i_q[7:0]};
        a_next_s    = lfsr_step(a_q);
        sis_h_s     = h_q;
        if (x_q[i_q[6:0]]) begin
            sis_h_s[{i_q[3:0], 4'b0000} +: 16] = h_q[{i_q[3:0], 4'b0000} +: 16] + a_next_s;
        end else begin
            sis_h_s = h_q;
        end
        round_key_s = key_q[{i_q[1:0], 6'b000000} +: 64] ^ {48'd0, i_q};
    end

    // Next state: accept, iterate, hand off between stages, finish
    always_comb begin
        state_d    = state_q;
        mode_d     = mode_q;
        key_d      = key_q;
        x_d        = x_q;
        w_d        = w_q;
        h_d        = h_q;
        a_d        = a_q;
        i_d        = i_q;
        data_out_d = data_out_q;
        done_d     = done_q;
        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (state_q == ST_DONE && !done_q) begin
                    // an invalid mode parks here for one cycle before completing
                    done_d     = 1'b1;
                    data_out_d = 256'd0;
                end else if (start) begin
                    mode_d = mode;
                    key_d  = master_key;
                    x_d    = data_in;
                    w_d    = data_in;
                    h_d    = 256'd0;
                    a_d    = LFSR_SEED;
                    i_d    = 16'd0;
                    done_d = 1'b0;
                    case (mode)
                        MODE_RFT, MODE_PIPE: state_d = ST_RFT;
                        MODE_SIS:            state_d = ST_SIS;
                        MODE_FEI:            state_d = ST_FEI;
                        default:             state_d = ST_DONE;
                    endcase
                end else begin
                    state_d = state_q;
                end
            end
            ST_RFT: begin
                w_d = rft_s_s;
                i_d = i_q + 16'd1;
                if (i_q == RFT_LAST) begin
                    i_d = 16'd0;
                    if (mode_q == MODE_PIPE) begin
                        state_d = ST_SIS;
                        x_d     = x_q ^ rft_s_s;
                    end else begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        data_out_d = {rft_s_s, x_q ^ rft_s_s};
                    end
                end else begin
                    state_d = ST_RFT;
                end
            end
            ST_SIS: begin
                a_d = a_next_s;
                h_d = sis_h_s;
                i_d = i_q + 16'd1;
                if (i_q == SIS_LAST) begin
                    i_d = 16'd0;
                    if (mode_q == MODE_PIPE) begin
                        state_d = ST_FEI;
                        w_d     = sis_h_s[255:128] ^ sis_h_s[127:0];
                    end else begin
                        state_d    = ST_DONE;
                        done_d     = 1'b1;
                        data_out_d = sis_h_s;
                    end
                end else begin
                    state_d = ST_SIS;
                end
            end
            ST_FEI: begin
                w_d = {fei_l_s, fei_r_s};
                i_d = i_q + 16'd1;
                if (i_q == FEI_LAST) begin
                    i_d        = 16'd0;
                    state_d    = ST_DONE;
                    done_d     = 1'b1;
                    data_out_d = {(mode_q == MODE_PIPE) ? h_q[255:128] : 128'd0, fei_l_s, fei_r_s};
                end else begin
                    state_d = ST_FEI;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and datapath registers
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            mode_q     <= 3'd0;
            key_q      <= 256'd0;
            x_q        <= 128'd0;
            w_q        <= 128'd0;
            h_q        <= 256'd0;
            a_q        <= 16'd0;
            i_q        <= 16'd0;
            data_out_q <= 256'd0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            mode_q     <= mode_d;
            key_q      <= key_d;
            x_q        <= x_d;
            w_q        <= w_d;
            h_q        <= h_d;
            a_q        <= a_d;
            i_q        <= i_d;
            data_out_q <= data_out_d;
            done_q     <= done_d;
        end
    end

    assign data_out = data_out_q;
    assign done     = done_q;

`ifdef QUANTONIUM_METRICS_EN
    logic [31:0] e_q, e_d, energy_q, energy_d, thr_q, thr_d;
    logic [15:0] sq_s, cr_q, cr_d;
    logic [5:0]  frc_q, frc_d;

    // Metrics follow whichever stage is iterating; throughput counts entries into DONE
    always_comb begin
        sq_s     = 16'(rft_x_s) * 16'(rft_x_s);
        e_d      = e_q;
        energy_d = energy_q;
        cr_d     = cr_q;
        frc_d    = frc_q;
        thr_d    = thr_q;
        if (state_q == ST_RFT) begin
            e_d = ((i_q == 16'd0) ? 32'd0 : e_q) + {16'd0, sq_s};
            if (i_q == RFT_LAST) begin
                energy_d = e_d;
            end else begin
                energy_d = energy_q;
            end
        end else if (state_q == ST_SIS) begin
            if (i_q == SIS_LAST) begin
                cr_d = popcount256(sis_h_s);
            end else begin
                cr_d = cr_q;
            end
        end else if (state_q == ST_FEI) begin
            frc_d = 6'(i_q + 16'd1);
        end else begin
            e_d = e_q;
        end
        if (done_d && !done_q) begin
            thr_d = thr_q + 32'd1;
        end else begin
            thr_d = thr_q;
        end
    end

    // Metric registers
    always_ff @(posedge clk) begin
        if (reset) begin
            e_q      <= 32'd0;
            energy_q <= 32'd0;
            cr_q     <= 16'd0;
            frc_q    <= 6'd0;
            thr_q    <= 32'd0;
        end else begin
            e_q      <= e_d;
            energy_q <= energy_d;
            cr_q     <= cr_d;
            frc_q    <= frc_d;
            thr_q    <= thr_d;
        end
    end

    assign rft_energy               = energy_q;
    assign sis_collision_resistance = cr_q;
    assign feistel_round_count      = frc_q;
    assign pipeline_throughput      = thr_q;
`else
    assign rft_energy               = 32'd0;
    assign sis_collision_resistance = 16'd0;
    assign feistel_round_count      = 6'd0;
    assign pipeline_throughput      = 32'd0;
`endif

endmodule

// File: tb/tb_quantonium_unified_core.sv
// Directed bench for quantonium_unified_core: every output is compared each cycle against a spec-level model.
module tb_quantonium_unified_core;

    logic         clk = 1'b0;
    logic         reset, start;
    logic [2:0]   mode;
    logic [255:0] master_key;
    logic [127:0] data_in;
    logic [255:0] data_out;
    logic         done;
    logic [31:0]  rft_energy, thr;
    logic [15:0]  sis_cr;
    logic [5:0]   frc;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    logic         exp_done;
    logic [255:0] exp_dout;
    logic [31:0]  exp_energy, exp_thr;
    logic [15:0]  exp_cr;
    logic [5:0]   exp_frc;

`ifdef QUANTONIUM_METRICS_EN
    localparam bit MET = 1'b1;
`else
    localparam bit MET = 1'b0;
`endif

    localparam logic [127:0] V0 = 128'h000102030405060708090A0B0C0D0E0F;
    localparam logic [127:0] V1 = 128'h112233445566778899AABBCCDDEEFF00;
    localparam logic [127:0] V2 = 128'h00112233445566778899AABBCCDDEEFF;
    localparam logic [255:0] K1 = 256'h000102030405060708090A0B0C0D0E0F101112131415161718191A1B1C1D1E1F;
    localparam logic [255:0] K3 = 256'h0BADF00DDEADBEEFCAFEBABE0123456776543210FEEDFACE1357924689ABCDEF;

    always #5 clk = ~clk;

    quantonium_unified_core dut (
        .clk                      (clk),
        .reset                    (reset),
        .start                    (start),
        .mode                     (mode),
        .master_key               (master_key),
        .data_in                  (data_in),
        .data_out                 (data_out),
        .done                     (done),
        .rft_energy               (rft_energy),
        .sis_collision_resistance (sis_cr),
        .feistel_round_count      (frc),
        .pipeline_throughput      (thr)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] m_lfsr(input logic [15:0] a);
        return a[0] ? ((a >> 1) ^ 16'hB400) : (a >> 1);
    endfunction

    function automatic logic [255:0] m_rft(input logic [127:0] x, output logic [31:0] e);
        logic [127:0] s;
        logic [7:0]   b;
        s = x;
        e = 32'd0;
        for (int i = 0; i < 64; i++) begin
            b = x[8*(i%16) +: 8];
            e = e + 32'(b) * 32'(b);
            s = {s[119:0], s[127:120]} ^ {120'd0, b ^ 8'(i)};
        end
        return {s, x ^ s};
    endfunction

    function automatic logic [255:0] m_sis(input logic [127:0] x);
        logic [15:0]  lane [16];
        logic [15:0]  a;
        logic [255:0] h;
        a = 16'hACE1;
        for (int j = 0; j < 16; j++) lane[j] = 16'd0;
        for (int i = 0; i < 512; i++) begin
            a = m_lfsr(a);
            if (x[i%128]) lane[i%16] = lane[i%16] + a;
        end
        for (int j = 0; j < 16; j++) h[16*j +: 16] = lane[j];
        return h;
    endfunction

    function automatic logic [127:0] m_fei(input logic [127:0] x, input logic [255:0] key);
        logic [63:0] l, r, k, t, f;
        l = x[127:64];
        r = x[63:0];
        for (int rd = 0; rd < 48; rd++) begin
            k = key[64*(rd%4) +: 64] ^ 64'(rd);
            t = r + k;
            f = {t[50:0], t[63:51]} ^ (r >> 7);
            t = l ^ f;
            l = r;
            r = t;
        end
        return {l, r};
    endfunction

    // Per-cycle comparison of every output against the model, on the inactive edge
    always @(negedge clk) begin
        if (chk_en) begin
            check("done", 256'(done), 256'(exp_done));
            check("data_out", data_out, exp_dout);
            check("rft_energy", 256'(rft_energy), MET ? 256'(exp_energy) : 256'd0);
            check("sis_collision_resistance", 256'(sis_cr), MET ? 256'(exp_cr) : 256'd0);
            check("feistel_round_count", 256'(frc), MET ? 256'(exp_frc) : 256'd0);
            check("pipeline_throughput", 256'(thr), MET ? 256'(exp_thr) : 256'd0);
        end
    end

    task automatic run_op(input logic [2:0] m, input logic [255:0] key, input logic [127:0] din,
                          input int lat, input int pulse_at, input int abort_at);
        logic [255:0] res, h;
        logic [31:0]  e;
        int           total;
        bit           aborted;
        e = 32'd0;
        h = 256'd0;
        aborted = 1'b0;
        case (m)
            3'd0: res = m_rft(din, e);
            3'd1: begin h = m_sis(din); res = h; end
            3'd2: res = {128'd0, m_fei(din, key)};
            3'd3: begin
                res = m_rft(din, e);
                h   = m_sis(res[127:0]);
                res = {h[255:128], m_fei(h[255:128] ^ h[127:0], key)};
            end
            default: res = 256'd0;
        endcase
        @(negedge clk);
        start = 1'b1; mode = m; master_key = key; data_in = din;
        @(posedge clk); #1;
        start = 1'b0;
        exp_done = 1'b0;
        total = (abort_at > 0) ? lat + 8 : lat;
        for (int c = 1; c <= total; c++) begin
            @(posedge clk); #1;
            if (aborted) begin
                aborted = 1'b1;
            end else if (abort_at > 0 && c == abort_at + 1) begin
                reset = 1'b0;
                aborted = 1'b1;
                exp_done = 1'b0; exp_dout = 256'd0; exp_energy = 32'd0;
                exp_cr = 16'd0; exp_frc = 6'd0; exp_thr = 32'd0;
            end else begin
                if ((m == 3'd0 || m == 3'd3) && c == 64) exp_energy = e;
                if ((m == 3'd1 && c == 512) || (m == 3'd3 && c == 576)) exp_cr = 16'($countones(h));
                if (m == 3'd2) exp_frc = 6'(c);
                if (m == 3'd3 && c > 576) exp_frc = 6'(c - 576);
                if (c == lat) begin
                    exp_done = 1'b1;
                    exp_dout = res;
                    exp_thr  = exp_thr + 32'd1;
                end
            end
            if (abort_at > 0 && c == abort_at) reset = 1'b1;
            if (pulse_at > 0 && c == pulse_at) begin
                start = 1'b1; mode = 3'd0; data_in = ~din;
            end
            if (pulse_at > 0 && c == pulse_at + 1) start = 1'b0;
        end
    endtask

    initial begin
        logic [31:0]  e0;
        logic [255:0] r0;
        reset = 1'b1; start = 1'b0; mode = 3'd0; master_key = 256'd0; data_in = 128'd0;
        exp_done = 1'b0; exp_dout = 256'd0; exp_energy = 32'd0;
        exp_cr = 16'd0; exp_frc = 6'd0; exp_thr = 32'd0;

        // hand-computed anchors for the model itself
        check("pin_lfsr_first", 256'(m_lfsr(16'hACE1)), 256'(16'hE270));
        r0 = m_rft(128'd0, e0);
        check("pin_rft_zero_cancels", r0, 256'd0);
        r0 = m_rft(V0, e0);
        check("pin_rft_energy", 256'(e0), 256'd4960);

        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        chk_en = 1'b1;

        run_op(3'd0, 256'd0, V0, 64, 0, 0);
        check("rft_xor_relation", 256'(data_out[127:0]), 256'(data_in ^ data_out[255:128]));
        check("rft_energy_4960", 256'(rft_energy), MET ? 256'd4960 : 256'd0);
        run_op(3'd2, K1, V2, 48, 0, 0);
        check("fei_upper_zero", 256'(data_out[255:128]), 256'd0);
        check("fei_rounds_48", 256'(frc), MET ? 256'd48 : 256'd0);
        run_op(3'd1, 256'd0, V1, 512, 0, 0);
        check("sis_popcount", 256'(sis_cr), MET ? 256'($countones(data_out)) : 256'd0);
        run_op(3'd3, K3, V0, 624, 0, 0);
        check("throughput_4", 256'(thr), MET ? 256'd4 : 256'd0);
        run_op(3'd5, K3, V2, 1, 0, 0);
        check("invalid_zero_out", data_out, 256'd0);
        run_op(3'd2, K1, V2, 48, 20, 0);
        run_op(3'd0, 256'd0, V0, 64, 0, 30);
        run_op(3'd0, 256'd0, V1, 64, 0, 0);
        repeat (3) @(posedge clk);
        #1 chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/quantonium_unified_core.md
# quantonium_unified_core

Top-level QuantoniumOS crypto engine. It runs one of four operations selected by `mode`: an RFT mixing transform, an SIS lattice hash, a 48-round Feistel encryption, or all three chained as a pipeline. It sits behind a start/done handshake and exports per-operation metrics. All stages are iterative, one step per clock.

## Interface
- `RFT_SIZE`, 64: RFT iterations; multiple of 16, ≤ 256.
- `SIS_N`, 512: SIS iterations (lattice columns).
- `FEISTEL_ROUNDS`, 48: Feistel rounds; ≤ 63.
- `clk` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request; sampled only in IDLE/DONE.
- `mode` in 3: 0=RFT, 1=SIS, 2=Feistel, 3=pipeline, 4–7 invalid.
- `master_key` in 256: Feistel key, words K0..K3 = [63:0]..[255:192].
- `data_in` in 128: operand, bytes B0..B15 = [7:0]..[127:120].
- `data_out` out 256: result, registered.
- `done` out 1: result valid (level).
- `rft_energy` out 32: last RFT energy.
- `sis_collision_resistance` out 16: popcount of last SIS hash.
- `feistel_round_count` out 6: Feistel rounds completed in the current or last operation.
- `pipeline_throughput` out 32: completed operations since reset.

## Operation
- States: IDLE, RFT, SIS, FEI, DONE. `start` in IDLE/DONE latches `mode`, `data_in`, `master_key`, clears `done`, and enters the first stage. Modes 4–7 go directly to DONE with `data_out`=0.
- RFT (input X): state S=X, E=0.
  - Iteration i=0..RFT_SIZE-1: x=X byte (i mod 16); E+=x*x; S=rotl128(S,8) ^ {120'b0, x ^ i[7:0]}.
  - Result {S, X^S}. `rft_energy`=E.
- SIS (input X): 16-bit Galois LFSR `a`, seed 0xACE1, taps 0xB400, advanced once per iteration before use. Hash H is 16 lanes of 16 bits, all 0.
  - Iteration i=0..SIS_N-1: if X bit (i mod 128) is set, lane (i mod 16) += a, mod 2^16.
  - Result H, with lane j at [16j+15:16j]. `sis_collision_resistance`=popcount(H).
- Feistel (input X): L=X[127:64], R=X[63:0].
  - Round r: k=K(r mod 4) ^ r. F=rotl64(R+k, 13) ^ (R>>7). Then (L,R)=(R, L^F).
  - Result {128'b0, L, R}. `feistel_round_count` increments each round.
- Pipeline: RFT on `data_in`, then SIS on the RFT low 128 bits, then Feistel on H[255:128]^H[127:0]. `data_out`={H[255:128], L, R}.
- Mode 0/1/2 `data_out` is the single-stage result.
- Entering DONE: `done`=1 and `pipeline_throughput`+=1, including for invalid modes.

## Timing
- Reset: all outputs 0, state IDLE. Reset mid-operation aborts with no `done`.
- Accept edge A: `done` falls at A. Stage iterations occur on the following edges. `done` and `data_out` update on the edge of the final iteration.
- Latency from A to `done` high: RFT_SIZE (mode 0), SIS_N (mode 1), FEISTEL_ROUNDS (mode 2), sum of all three (mode 3), 1 (invalid).
- Stage handoff costs no extra cycle.
- `start` while busy is ignored.
- `done` holds until the next accepted `start` or reset.
- Metrics hold their last values until overwritten by their own stage.

## Configuration
- `QUANTONIUM_METRICS_EN` defined: all four metric outputs function as specified.
- Undefined: the four metric outputs are constant 0. Their accumulators and popcount logic are removed. `data_out`/`done` behaviour is unchanged.

## Structure
- Package `quantonium_pkg` holds:
  - mode and state enums;
  - LFSR seed and taps;
  - rotation constants 8, 13, 7;
  - function `feistel_f`.
- Sub-module `quantonium_feistel_round` (combinational: L, R, k → L', R'). Everything else lives in the core.

## Test plan
- Mode 0, `data_in`=0x000102…0E0F → `done` 64 cycles after accept; `rft_energy`=4960; `data_out`[127:0] equals `data_in` ^ `data_out`[255:128].
- Mode 2, key 0x00010203…1C1D1E1F, `data_in`=0x00112233…CCDDEEFF → `done` after 48 cycles; `feistel_round_count`=48; `data_out`[255:128]=0; matches reference model.
- Mode 1, `data_in`=0x11223344…DDEEFF00 → `done` after 512 cycles; `sis_collision_resistance`=popcount(`data_out`).
- Mode 3, key 0x0BADF00D…89ABCDEF → `done` after 624 cycles; after the four runs `pipeline_throughput`=4.
- Mode 5 → `done` 1 cycle after accept, `data_out`=0. A `start` pulse mid-run is ignored (same result and latency).
- Assert `reset` at cycle 30 of mode 0 → all outputs 0, no `done`. A following mode-0 run completes normally.
